// File: rtl/hazard_forward_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit_if
//   Bundles the ID-stage hazard inputs and the forwarding/stall/flush outputs
//   exchanged between the pipeline and the hazard/forwarding unit.
//
//   master : pipeline side (drives ID fields and BRANCH_TAKEN)
//   slave  : hazard unit side (drives forward selects, stall/flush, counters)
//
//   RS1_ID/RS2_ID      ID source register indices
//   USES_RS1_ID/RS2_ID ID instruction actually reads that source
//   RD_ID              ID destination index
//   RegWrite_ID        ID instruction writes the register file
//   MemRead_ID         ID instruction is a load
//   BRANCH_TAKEN       branch in EX is taken (single-cycle pulse)
//   forwardA/forwardB  registered operand selects for EX (00 RF, 01 WB, 10 MEM)
//   PC_WRITE           PC update enable
//   IF_ID_WRITE        IF/ID update enable
//   ID_EX_BUBBLE       insert NOP into ID/EX on the next edge
//   IF_ID_FLUSH        clear IF/ID on the next edge
//   STALL_COUNT        saturating load-use stall counter
//   FLUSH_COUNT        saturating branch flush counter
// ---------------------------------------------------------------------------
interface hazard_forward_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       RS1_ID;
    logic [4:0]       RS2_ID;
    logic             USES_RS1_ID;
    logic             USES_RS2_ID;
    logic [4:0]       RD_ID;
    logic             RegWrite_ID;
    logic             MemRead_ID;
    logic             BRANCH_TAKEN;
    logic [1:0]       forwardA;
    logic [1:0]       forwardB;
    logic             PC_WRITE;
    logic             IF_ID_WRITE;
    logic             ID_EX_BUBBLE;
    logic             IF_ID_FLUSH;
    logic [CNT_W-1:0] STALL_COUNT;
    logic [CNT_W-1:0] FLUSH_COUNT;

    modport master (
        output RS1_ID, RS2_ID, USES_RS1_ID, USES_RS2_ID, RD_ID,
               RegWrite_ID, MemRead_ID, BRANCH_TAKEN,
        input  forwardA, forwardB, PC_WRITE, IF_ID_WRITE, ID_EX_BUBBLE,
               IF_ID_FLUSH, STALL_COUNT, FLUSH_COUNT
    );

    modport slave (
        input  RS1_ID, RS2_ID, USES_RS1_ID, USES_RS2_ID, RD_ID,
               RegWrite_ID, MemRead_ID, BRANCH_TAKEN,
        output forwardA, forwardB, PC_WRITE, IF_ID_WRITE, ID_EX_BUBBLE,
               IF_ID_FLUSH, STALL_COUNT, FLUSH_COUNT
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//   Control side of the execute-stage operand datapath. Tracks a shadow copy
//   of the EX/MEM/WB destination and control bits, produces registered
//   forwardA/forwardB selects for the instruction entering EX, detects
//   load-use hazards (one-cycle stall) and applies branch flushes.
//
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    hazard_forward_unit_if.slave (see interface header for signals)
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_forward_unit_if.slave  bus
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } stage_t;

    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    stage_t           stage_q [3];
    stage_t           ex_d;
    logic [1:0]       fwd_q   [2];
    logic [1:0]       fwd_d   [2];
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic [4:0]       src_idx [2];
    logic             src_use [2];
    logic             ex_hit  [2];
    logic             mem_hit [2];

    logic             branch;
    logic             stall;
    logic             bubble;

    assign src_idx[0] = bus.RS1_ID;
    assign src_idx[1] = bus.RS2_ID;
    assign src_use[0] = bus.USES_RS1_ID;
    assign src_use[1] = bus.USES_RS2_ID;

    // Per-source match against the EX and MEM shadow stages, and the select
    // that will be registered as the instruction moves into EX.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign ex_hit[gi]  = src_use[gi] && stage_q[EX].valid && stage_q[EX].regwrite
                             && (stage_q[EX].rd != 5'd0) && (stage_q[EX].rd == src_idx[gi]);
        assign mem_hit[gi] = src_use[gi] && stage_q[MEM].valid && stage_q[MEM].regwrite
                             && (stage_q[MEM].rd != 5'd0) && (stage_q[MEM].rd == src_idx[gi]);

        // A load in EX is never forwarded from MEM-ALU; that case is a stall
        // and the bubble forces RF here anyway, the memread test keeps the
        // select well-defined on its own.
        always_comb begin
            fwd_d[gi] = FWD_RF;
            if (!bubble) begin
                if (ex_hit[gi] && !stage_q[EX].memread) begin
                    fwd_d[gi] = FWD_MEM;
                end else if (mem_hit[gi]) begin
                    fwd_d[gi] = FWD_WB;
                end
            end
        end
    end

    // Gated by reset so the flush controls read inactive while held in reset.
    assign branch = bus.BRANCH_TAKEN && rst_n;
    assign stall  = stage_q[EX].memread && (ex_hit[0] || ex_hit[1]);
    assign bubble = branch || stall;

    // A taken branch overrides the stall: the dependent instruction is being
    // squashed, so the front end keeps moving to the branch target.
    assign bus.PC_WRITE     = branch || !stall;
    assign bus.IF_ID_WRITE  = branch || !stall;
    assign bus.ID_EX_BUBBLE = bubble;
    assign bus.IF_ID_FLUSH  = branch;

    assign bus.forwardA    = fwd_q[0];
    assign bus.forwardB    = fwd_q[1];
    assign bus.STALL_COUNT = stall_cnt_q;
    assign bus.FLUSH_COUNT = flush_cnt_q;

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = bus.RD_ID;
            ex_d.regwrite = bus.RegWrite_ID;
            ex_d.memread  = bus.MemRead_ID;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                stage_q[i] <= '0;
            end
            fwd_q[0]    <= FWD_RF;
            fwd_q[1]    <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stage_q[WB]  <= stage_q[MEM];
            stage_q[MEM] <= stage_q[EX];
            stage_q[EX]  <= ex_d;
            fwd_q[0]     <= fwd_d[0];
            fwd_q[1]     <= fwd_d[1];
            if (stall && !branch && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (branch && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

endmodule
